// File: rtl/ps2_turn_arbiter_if.sv
// Handshake/status bundle between the PS/2 turn arbiter (master) and the game core (slave).
interface ps2_turn_arbiter_if;
    logic [8:0] choice_key;
    logic       choice_valid;
    logic       choice_ready;
    logic [8:0] set_key;
    logic       set_valid;
    logic       set_ready;
    logic       place_done;
    logic       place_fail;
    logic       game_over;
    logic [1:0] phase;
    logic       frame_err;
    logic       overflow;
    logic       led;

    modport master (
        output choice_key, choice_valid, set_key, set_valid, phase, frame_err, overflow, led,
        input  choice_ready, set_ready, place_done, place_fail, game_over
    );
    modport slave (
        input  choice_key, choice_valid, set_key, set_valid, phase, frame_err, overflow, led,
        output choice_ready, set_ready, place_done, place_fail, game_over
    );
endinterface

// File: rtl/ps2_turn_arbiter.sv
// Shared PS/2 receiver/decoder plus turn-phase FSM routing make codes to choice or set layer.
// Optional: PS2_TYPEMATIC_FILTER_EN drops auto-repeat makes of the last key until its break.
module ps2_turn_arbiter #(
    parameter int         FILT_LEN    = 8,
    parameter int         TIMEOUT_CYC = 216000,
    parameter logic [7:0] KEY_ENTER   = 8'h5A,
    parameter logic [7:0] KEY_ESC     = 8'h76
) (
    input  logic               iCLK,
    input  logic               reset,
    input  logic               ps2Clk,
    input  logic               ps2Dat,
    ps2_turn_arbiter_if.master bus
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {CHOOSE = 2'd0, PLACE = 2'd1, HOLD = 2'd2, OVER = 2'd3} phase_e;

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [10:0]   sh_q, sh_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          frame_err_q, frame_err_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          buf_vld_q, buf_vld_d;
    logic [8:0]    buf_q, buf_d;
    logic          overflow_q, overflow_d;
    phase_e        phase_q, phase_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0]    last_q, last_d;
    logic          last_vld_q, last_vld_d;
`endif

    logic       fall;
    logic       make;
    logic [8:0] code;
    logic       buf_is_esc, buf_is_enter;
    logic       choice_vld, set_vld, choice_xfer, set_xfer, phase_chg;

    // Receiver: sync, glitch filter on clock, 11-bit shift on filtered falling edge.
    always_comb begin
        clk_s1_d    = ps2Clk;
        clk_s2_d    = clk_s1_q;
        dat_s1_d    = ps2Dat;
        dat_s2_d    = dat_s1_q;
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = '0;
        fall        = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        to_cnt_d    = '0;
        byte_vld_d  = 1'b0;
        byte_d      = byte_q;
        frame_err_d = 1'b0;

        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                filt_clk_d = clk_s2_q;
                fall       = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end

        if (fall) begin
            sh_d = {dat_s2_q, sh_q[10:1]};
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                // start low, stop high, odd parity over data+parity
                if (!sh_d[0] && sh_d[10] && (^sh_d[9:1])) begin
                    byte_vld_d = 1'b1;
                    byte_d     = sh_d[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (bit_cnt_q != '0) begin
            if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d   = '0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // Decoder, phase FSM and the single shared output buffer.
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        make  = 1'b0;
        code  = {ext_q, byte_q};
        if (byte_vld_q) begin
            if (byte_q == 8'hE0)      ext_d = 1'b1;
            else if (byte_q == 8'hF0) brk_d = 1'b1;
            else begin
                make  = !brk_q;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (byte_vld_q && byte_q != 8'hE0 && byte_q != 8'hF0) begin
            if (brk_q) begin
                if (last_vld_q && last_q == code) last_vld_d = 1'b0;
            end else if (last_vld_q && last_q == code) begin
                make = 1'b0;
            end else begin
                last_d     = code;
                last_vld_d = 1'b1;
            end
        end
`endif

        buf_is_esc   = (buf_q == {1'b0, KEY_ESC});
        buf_is_enter = (buf_q == {1'b0, KEY_ENTER});
        choice_vld   = buf_vld_q && (phase_q == CHOOSE);
        set_vld      = buf_vld_q && (phase_q == PLACE) && !buf_is_esc;
        choice_xfer  = choice_vld && bus.choice_ready;
        set_xfer     = set_vld && bus.set_ready;

        phase_d = phase_q;
        if (bus.game_over) phase_d = OVER;
        else begin
            case (phase_q)
                CHOOSE: if (choice_xfer && buf_is_enter) phase_d = PLACE;
                PLACE: begin
                    if (set_xfer && buf_is_enter)     phase_d = HOLD;
                    else if (buf_vld_q && buf_is_esc) phase_d = CHOOSE;
                end
                HOLD: begin
                    if (bus.place_done)      phase_d = CHOOSE;
                    else if (bus.place_fail) phase_d = PLACE;
                end
                default: phase_d = OVER;
            endcase
        end
        phase_chg = (phase_d != phase_q);

        buf_vld_d  = buf_vld_q;
        buf_d      = buf_q;
        overflow_d = 1'b0;
        if (phase_chg || choice_xfer || set_xfer) buf_vld_d = 1'b0;
        // A make landing on a phase change belongs to the old phase and is flushed with it.
        if (make && !phase_chg && (phase_q == CHOOSE || phase_q == PLACE)) begin
            if (buf_vld_q) overflow_d = 1'b1;
            else begin
                buf_vld_d = 1'b1;
                buf_d     = code;
            end
        end
    end

    always_ff @(posedge iCLK or negedge reset) begin
        if (!reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            to_cnt_q    <= '0;
            byte_vld_q  <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            buf_vld_q   <= 1'b0;
            buf_q       <= '0;
            overflow_q  <= 1'b0;
            phase_q     <= CHOOSE;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_q      <= '0;
            last_vld_q  <= 1'b0;
`endif
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            to_cnt_q    <= to_cnt_d;
            byte_vld_q  <= byte_vld_d;
            byte_q      <= byte_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            buf_vld_q   <= buf_vld_d;
            buf_q       <= buf_d;
            overflow_q  <= overflow_d;
            phase_q     <= phase_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_q      <= last_d;
            last_vld_q  <= last_vld_d;
`endif
        end
    end

    assign bus.choice_valid = choice_vld;
    assign bus.set_valid    = set_vld;
    assign bus.choice_key   = choice_vld ? buf_q : 9'd0;
    assign bus.set_key      = set_vld ? buf_q : 9'd0;
    assign bus.phase        = phase_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.overflow     = overflow_q;
    assign bus.led          = (phase_q == PLACE) || (phase_q == HOLD);
endmodule
